// File: rtl/bcnn_pkg.sv
// Shared types and constants for the binary-convolution engine.
package bcnn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_RD_DIM,
    S_FILL,
    S_CONV,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam int         KSIZE    = 3;
  localparam logic [3:0] THRESH   = 4'd5;
  localparam logic [15:0] TERM_DIM = 16'hFFFF;

  function automatic logic [3:0] popcount9(input logic [8:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 9; i++) s = s + {3'b000, v[i]};
    return s;
  endfunction

endpackage

// File: rtl/bcnn_conv_engine_if.sv
// Control and memory-port bundle between the conv engine and its SRAM/WMEM.
interface bcnn_conv_engine_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              dut_run;
  logic              dut_busy;
  logic [ADDR_W-1:0] dut_sram_read_address;
  logic [DATA_W-1:0] sram_dut_read_data;
  logic [ADDR_W-1:0] dut_wmem_read_address;
  logic [DATA_W-1:0] wmem_dut_read_data;
  logic              dut_sram_write_enable;
  logic [ADDR_W-1:0] dut_sram_write_address;
  logic [DATA_W-1:0] dut_sram_write_data;

  modport master (
    input  dut_run, sram_dut_read_data, wmem_dut_read_data,
    output dut_busy, dut_sram_read_address, dut_wmem_read_address,
           dut_sram_write_enable, dut_sram_write_address, dut_sram_write_data
  );

  modport slave (
    output dut_run, sram_dut_read_data, wmem_dut_read_data,
    input  dut_busy, dut_sram_read_address, dut_wmem_read_address,
           dut_sram_write_enable, dut_sram_write_address, dut_sram_write_data
  );
endinterface

// File: rtl/bcnn_xnor_pop.sv
// One output row for one kernel: XNOR-popcount-threshold over every 3x3 window.
module bcnn_xnor_pop
  import bcnn_pkg::*;
#(
  parameter int MAX_DIM = 16,
  parameter int DIM_W   = $clog2(MAX_DIM + 1)
) (
  input  logic [MAX_DIM-1:0] row0,
  input  logic [MAX_DIM-1:0] row1,
  input  logic [MAX_DIM-1:0] row2,
  input  logic [8:0]         kern,
  input  logic [DIM_W-1:0]   dim,
  output logic [MAX_DIM-3:0] bits
);

  // Patch bit 3r+c lines up with kernel bit 3r+c; columns past N-3 are forced low.
  for (genvar c = 0; c < MAX_DIM - 2; c++) begin : g_col
    logic [8:0] patch;
    assign patch   = {row2[c +: KSIZE], row1[c +: KSIZE], row0[c +: KSIZE]};
    assign bits[c] = (popcount9(~(patch ^ kern)) >= THRESH) && (32'(dim) > c + 2);
  end

endmodule

// File: rtl/bcnn_conv_engine.sv
// Multi-filter binary convolution engine: streams images from SRAM, kernels from
// WMEM, and writes one thresholded word per output row per filter.
module bcnn_conv_engine
  import bcnn_pkg::*;
#(
  parameter int                MAX_DIM  = 16,
  parameter int                NUM_FILT = 4,
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] IN_BASE  = '0,
  parameter logic [ADDR_W-1:0] OUT_BASE = ADDR_W'(12'h200)
) (
  input logic               clk,
  input logic               reset_b,
  bcnn_conv_engine_if.master bus
);

  localparam int DIM_W = $clog2(MAX_DIM + 1);
  localparam int FW    = $clog2(NUM_FILT) + 1;

  state_t                state_q, state_d;
  logic                  phase_q;
  logic [FW-1:0]         filt_q;
  logic [DIM_W-1:0]      dim_q, row_idx_q;
  logic [ADDR_W-1:0]     in_ptr_q, out_idx_q;
  logic [MAX_DIM-1:0]    win_q [KSIZE];
  logic [NUM_FILT*9-1:0] kern_q;
  logic                  busy_q, we_q;
  logic [ADDR_W-1:0]     wr_addr_q;
  logic [DATA_W-1:0]     wr_data_q;

  logic [ADDR_W-1:0]     sram_addr, wmem_addr, row_addr;
  logic [DATA_W-1:0]     rd_data;
  logic [8:0]            cur_kern;
  logic [MAX_DIM-3:0]    conv_bits;
  logic                  last_filt, more_rows, hdr_ok;
  logic                  unused_wmem_hi;

  assign rd_data        = bus.sram_dut_read_data;
  assign unused_wmem_hi = ^bus.wmem_dut_read_data[DATA_W-1:9];
  assign cur_kern       = kern_q[int'(filt_q)*9 +: 9];
  assign last_filt      = (filt_q == FW'(NUM_FILT - 1));
  assign more_rows      = (row_idx_q < dim_q);
  assign row_addr       = in_ptr_q + ADDR_W'(1) + ADDR_W'(row_idx_q);
  assign hdr_ok         = (rd_data != DATA_W'(TERM_DIM)) &&
                          (rd_data >= DATA_W'(KSIZE)) &&
                          (rd_data <= DATA_W'(MAX_DIM));

  bcnn_xnor_pop #(.MAX_DIM(MAX_DIM), .DIM_W(DIM_W)) u_xnor_pop (
    .row0 (win_q[0]),
    .row1 (win_q[1]),
    .row2 (win_q[2]),
    .kern (cur_kern),
    .dim  (dim_q),
    .bits (conv_bits)
  );

  always_ff @(posedge clk) begin
    if (reset_b) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every variable gets a default before the case so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    sram_addr = '0;
    wmem_addr = '0;
    case (state_q)
      S_IDLE:   if (bus.dut_run) state_d = S_LOAD_W;
      S_LOAD_W: begin
        wmem_addr = ADDR_W'(filt_q);
        if (phase_q && last_filt) state_d = S_RD_DIM;
      end
      S_RD_DIM: begin
        sram_addr = in_ptr_q;
        if (phase_q) state_d = hdr_ok ? S_FILL : S_DONE;
      end
      S_FILL: begin
        sram_addr = row_addr;
        if (phase_q && row_idx_q == DIM_W'(KSIZE - 1)) state_d = S_CONV;
      end
      S_CONV:   if (last_filt) state_d = more_rows ? S_SHIFT : S_RD_DIM;
      S_SHIFT: begin
        sram_addr = row_addr;
        if (phase_q) state_d = S_CONV;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: window and kernel file are plain flops, so they are cleared with everything else on reset.
  always_ff @(posedge clk) begin
    if (reset_b) begin
      phase_q   <= 1'b0;
      filt_q    <= '0;
      dim_q     <= '0;
      row_idx_q <= '0;
      in_ptr_q  <= '0;
      out_idx_q <= '0;
      kern_q    <= '0;
      for (int i = 0; i < KSIZE; i++) win_q[i] <= '0;
      busy_q    <= 1'b0;
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      // NOTE: non-blocking so every register here sees pre-edge values of the others.
      busy_q <= (state_q != S_IDLE) || (state_d != S_IDLE);
      we_q   <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.dut_run) begin
          phase_q   <= 1'b0;
          filt_q    <= '0;
          in_ptr_q  <= IN_BASE;
          out_idx_q <= '0;
        end
        S_LOAD_W: begin
          phase_q <= ~phase_q;
          if (phase_q) begin
            kern_q[int'(filt_q)*9 +: 9] <= bus.wmem_dut_read_data[8:0];
            filt_q <= last_filt ? '0 : filt_q + FW'(1);
          end
        end
        S_RD_DIM: begin
          phase_q <= ~phase_q;
          if (phase_q) begin
            dim_q     <= rd_data[DIM_W-1:0];
            row_idx_q <= '0;
          end
        end
        S_FILL, S_SHIFT: begin
          phase_q <= ~phase_q;
          if (phase_q) begin
            win_q[0]  <= win_q[1];
            win_q[1]  <= win_q[2];
            win_q[2]  <= rd_data[MAX_DIM-1:0];
            row_idx_q <= row_idx_q + DIM_W'(1);
          end
        end
        S_CONV: begin
          we_q      <= 1'b1;
          wr_addr_q <= OUT_BASE + out_idx_q;
          wr_data_q <= DATA_W'(conv_bits);
          out_idx_q <= out_idx_q + ADDR_W'(1);
          filt_q    <= last_filt ? '0 : filt_q + FW'(1);
          // Skip header and all N rows so the next header is read.
          if (last_filt && !more_rows) in_ptr_q <= in_ptr_q + ADDR_W'(dim_q) + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.dut_busy               = busy_q;
  assign bus.dut_sram_read_address  = sram_addr;
  assign bus.dut_wmem_read_address  = wmem_addr;
  assign bus.dut_sram_write_enable  = we_q;
  assign bus.dut_sram_write_address = wr_addr_q;
  assign bus.dut_sram_write_data    = wr_data_q;

endmodule

// File: tb/tb_bcnn_conv_engine.sv
// Scoreboard bench: two engines (1 and 2 filters) against behavioural SRAM/WMEM.
module tb_bcnn_conv_engine;

  typedef logic [15:0] img_t [16];

  logic clk;
  logic reset_b;

  bcnn_conv_engine_if #(.ADDR_W(12), .DATA_W(16)) bus1 ();
  bcnn_conv_engine_if #(.ADDR_W(12), .DATA_W(16)) bus2 ();

  bcnn_conv_engine #(.NUM_FILT(1)) u_dut1 (.clk(clk), .reset_b(reset_b), .bus(bus1));
  bcnn_conv_engine #(.NUM_FILT(2)) u_dut2 (.clk(clk), .reset_b(reset_b), .bus(bus2));

  logic [15:0] sram1 [4096];
  logic [15:0] wmem1 [4096];
  logic [15:0] sram2 [4096];
  logic [15:0] wmem2 [4096];

  logic [63:0] exp_q [$];
  int n_vec  = 0;
  int n_err  = 0;
  int wr_seen = 0;
  int wp;
  int oidx;
  img_t img;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus1.sram_dut_read_data <= sram1[bus1.dut_sram_read_address];
    bus1.wmem_dut_read_data <= wmem1[bus1.dut_wmem_read_address];
    bus2.sram_dut_read_data <= sram2[bus2.dut_sram_read_address];
    bus2.wmem_dut_read_data <= wmem2[bus2.dut_wmem_read_address];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (bus1.dut_sram_write_enable) begin
      wr_seen++;
      if (exp_q.size() > 0)
        check("wr_dut1", {36'h0, bus1.dut_sram_write_address, bus1.dut_sram_write_data}, exp_q.pop_front());
    end
    if (bus2.dut_sram_write_enable) begin
      wr_seen++;
      if (exp_q.size() > 0)
        check("wr_dut2", {36'h0, bus2.dut_sram_write_address, bus2.dut_sram_write_data}, exp_q.pop_front());
    end
  end

  function automatic logic [15:0] ref_word(input img_t im, input int n, input int r, input logic [8:0] k);
    logic [15:0] w;
    int cnt;
    w = '0;
    for (int c = 0; c < n - 2; c++) begin
      cnt = 0;
      for (int dr = 0; dr < 3; dr++)
        for (int dc = 0; dc < 3; dc++)
          if (im[r+dr][c+dc] == k[3*dr+dc]) cnt++;
      w[c] = (cnt >= 5);
    end
    return w;
  endfunction

  function automatic logic [63:0] outs(input int sel);
    if (sel == 1)
      return {10'h0, bus1.dut_sram_write_enable, bus1.dut_busy, bus1.dut_sram_write_address,
              bus1.dut_sram_write_data, bus1.dut_sram_read_address, bus1.dut_wmem_read_address};
    return {10'h0, bus2.dut_sram_write_enable, bus2.dut_busy, bus2.dut_sram_write_address,
            bus2.dut_sram_write_data, bus2.dut_sram_read_address, bus2.dut_wmem_read_address};
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 1) ? bus1.dut_busy : bus2.dut_busy;
  endfunction

  function automatic logic get_we(input int sel);
    return (sel == 1) ? bus1.dut_sram_write_enable : bus2.dut_sram_write_enable;
  endfunction

  task automatic set_run(input int sel, input logic v);
    if (sel == 1) bus1.dut_run = v;
    else          bus2.dut_run = v;
  endtask

  task automatic begin_stream();
    wp   = 0;
    oidx = 0;
    exp_q.delete();
  endtask

  task automatic put(input int sel, input logic [15:0] v);
    if (sel == 1) sram1[wp] = v;
    else          sram2[wp] = v;
    wp++;
  endtask

  task automatic put_img(input int sel, input int n, input img_t im);
    put(sel, 16'(n));
    for (int r = 0; r < n; r++) put(sel, im[r]);
  endtask

  task automatic expect_img(input int n, input img_t im, input logic [8:0] k0,
                            input logic [8:0] k1, input int nf);
    for (int r = 0; r <= n - 3; r++)
      for (int f = 0; f < nf; f++) begin
        exp_q.push_back({36'h0, 12'(12'h200 + oidx), ref_word(im, n, r, (f == 0) ? k0 : k1)});
        oidx++;
      end
  endtask

  // Pulses run, then tracks first-write latency and the busy fall edge, counted in
  // rising edges after the one that sampled run.
  task automatic run_job(input int sel, input int nf, input int exp_total, input int exp_writes,
                         input bit dup_run, input int abort_at);
    int first_k, fall_k, we_cnt;
    bit aborted;
    first_k = -1;
    fall_k  = -1;
    we_cnt  = 0;
    aborted = 1'b0;
    wr_seen = 0;
    @(negedge clk) set_run(sel, 1'b1);
    @(posedge clk);
    @(negedge clk) set_run(sel, 1'b0);
    check("busy_rise", 64'(get_busy(sel)), 64'd1);
    for (int k = 1; k <= 3000; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (dup_run) set_run(sel, k == 1);
      if (get_we(sel)) begin
        we_cnt++;
        if (first_k < 0) first_k = k;
      end
      if (abort_at > 0 && we_cnt == abort_at) begin
        reset_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_outs", outs(sel), 64'd0);
        @(posedge clk);
        @(negedge clk) reset_b = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (!get_busy(sel)) begin
        fall_k = k;
        break;
      end
    end
    if (exp_writes > 0) check("first_wr_lat", 64'(first_k), 64'(2 * nf + 9));
    if (!aborted) check("busy_fall", 64'(fall_k), 64'(exp_total));
  endtask

  task automatic finish_job(input int exp_writes);
    @(negedge clk);
    check("wr_count", 64'(wr_seen), 64'(exp_writes));
    check("sb_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_b      = 1'b1;
    bus1.dut_run = 1'b0;
    bus2.dut_run = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      sram1[i] = '0; wmem1[i] = '0; sram2[i] = '0; wmem2[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_dut1", outs(1), 64'd0);
    check("rst_dut2", outs(2), 64'd0);
    reset_b = 1'b0;

    // 4x4 all-ones region, all-ones kernel.
    begin_stream();
    wmem1[0] = 16'h01FF;
    img = '{default: '0};
    for (int r = 0; r < 4; r++) img[r] = 16'h000F;
    put_img(1, 4, img);
    expect_img(4, img, 9'h1FF, 9'h000, 1);
    put(1, 16'hFFFF);
    run_job(1, 1, 18, 2, 1'b0, 0);
    finish_job(2);

    // Same image, all-zeros kernel; output index restarts.
    begin_stream();
    wmem1[0] = 16'h0000;
    put_img(1, 4, img);
    expect_img(4, img, 9'h000, 9'h000, 1);
    put(1, 16'hFFFF);
    run_job(1, 1, 18, 2, 1'b0, 0);
    finish_job(2);

    // Threshold edge: popcount 5 then popcount 4, index runs across images.
    begin_stream();
    wmem1[0] = 16'h01FF;
    img = '{default: '0};
    img[0] = 16'h0007; img[1] = 16'h0003; img[2] = 16'h0000;
    put_img(1, 3, img);
    expect_img(3, img, 9'h1FF, 9'h000, 1);
    img[1] = 16'h0001;
    put_img(1, 3, img);
    expect_img(3, img, 9'h1FF, 9'h000, 1);
    put(1, 16'hFFFF);
    run_job(1, 1, 24, 2, 1'b0, 0);
    finish_job(2);

    // N=2 header ends the run at once; a run pulse during it must be ignored.
    begin_stream();
    put(1, 16'h0002);
    run_job(1, 1, 6, 0, 1'b1, 0);
    finish_job(0);
    repeat (5) @(negedge clk);
    check("busy_stays_low", 64'(bus1.dut_busy), 64'd0);

    // Two filters on a 5x5 all-ones region.
    begin_stream();
    wmem2[0] = 16'h01FF;
    wmem2[1] = 16'h0000;
    img = '{default: '0};
    for (int r = 0; r < 5; r++) img[r] = 16'h001F;
    put_img(2, 5, img);
    expect_img(5, img, 9'h1FF, 9'h000, 2);
    put(2, 16'hFFFF);
    run_job(2, 2, 26, 6, 1'b0, 0);
    finish_job(6);

    // Reset during the third write, then a clean rerun of the same stream.
    oidx = 0;
    exp_q.delete();
    expect_img(5, img, 9'h1FF, 9'h000, 2);
    run_job(2, 2, 26, 6, 1'b0, 3);
    @(negedge clk);
    check("wr_before_abort", 64'(wr_seen), 64'd3);
    exp_q.delete();
    repeat (20) @(negedge clk);
    check("no_wr_after_rst", 64'(wr_seen), 64'd3);
    check("idle_after_rst", outs(2), 64'd0);
    oidx = 0;
    expect_img(5, img, 9'h1FF, 9'h000, 2);
    run_job(2, 2, 26, 6, 1'b0, 0);
    finish_job(6);

    // Full 16x16 random image, mixed kernels with junk upper bits, N=17 ends the run.
    begin_stream();
    wmem2[0] = 16'hA0AA;
    wmem2[1] = 16'h7F55;
    for (int r = 0; r < 16; r++) img[r] = 16'($urandom);
    put_img(2, 16, img);
    expect_img(16, img, 9'h0AA, 9'h155, 2);
    put(2, 16'd17);
    run_job(2, 2, 70, 28, 1'b0, 0);
    finish_job(28);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
